// File: rtl/pc_int_sequencer_pkg.sv
// Shared widths and encodings for the PC/interrupt sequencer.
package jcr_pkg;
    localparam int ADDR_W_DEF     = 8;
    localparam int NUM_INT_DEF    = 4;
    localparam int NEST_DEPTH_DEF = 2;

    function automatic int chan_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Return-stack entry: {return pc, flag, interrupted channel}
    function automatic int entry_w(input int aw, input int n);
        return aw + 1 + chan_w(n);
    endfunction

    // "No channel active" is the out-of-range index n
    function automatic int chan_none(input int n);
        return n;
    endfunction
endpackage

// File: rtl/pc_int_sequencer_if.sv
// Controller <-> sequencer bundle: strobes, interrupt inputs, PC/status outputs.
interface pc_int_sequencer_if
    import jcr_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int NUM_INT = NUM_INT_DEF
) ();
    localparam int IDW = id_w(NUM_INT);

    logic                      jmp_en;
    logic                      je_en;
    logic                      ret;
    logic                      flag_w_en;
    logic                      alu_flag;
    logic [ADDR_W-1:0]         target;
    logic [NUM_INT-1:0]        int_req;
    logic [NUM_INT-1:0]        int_en;
    logic [NUM_INT*ADDR_W-1:0] int_vec;
    logic [ADDR_W-1:0]         pc;
    logic                      flag;
    logic                      in_isr;
    logic                      int_ack;
    logic [IDW-1:0]            int_ack_id;
    logic                      ret_err;

    modport master (
        output jmp_en, je_en, ret, flag_w_en, alu_flag, target, int_req, int_en, int_vec,
        input  pc, flag, in_isr, int_ack, int_ack_id, ret_err
    );

    modport slave (
        input  jmp_en, je_en, ret, flag_w_en, alu_flag, target, int_req, int_en, int_vec,
        output pc, flag, in_isr, int_ack, int_ack_id, ret_err
    );
endinterface

// File: rtl/pc_int_sequencer_ret_stack.sv
// LIFO of interrupt return state; push and pop are never asserted together by the owner.
module ret_stack #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]    mem_q [DEPTH];
    logic [CNTW-1:0] cnt_q;
    logic [IW-1:0]   top_idx;

    assign top_idx = IW'(cnt_q - CNTW'(1));
    assign full    = (cnt_q == CNTW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign dout    = empty ? '0 : mem_q[top_idx];

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push && !full) begin
            mem_q[IW'(cnt_q)] <= din;
            cnt_q             <= cnt_q + CNTW'(1);
        end else if (pop && !empty) begin
            cnt_q <= cnt_q - CNTW'(1);
        end
    end
endmodule

// File: rtl/pc_int_sequencer.sv
// PC, branch flag and prioritised interrupt entry/return for the core.
// INT_NEST_EN enables nesting up to NEST_DEPTH; otherwise a single ISR level.
module pc_int_sequencer
    import jcr_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int NUM_INT    = NUM_INT_DEF,
    parameter int NEST_DEPTH = NEST_DEPTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    pc_int_sequencer_if.slave bus
);
    localparam int CW  = chan_w(NUM_INT);
    localparam int IDW = id_w(NUM_INT);
    localparam int EW  = entry_w(ADDR_W, NUM_INT);
`ifdef INT_NEST_EN
    localparam int EFF_DEPTH = NEST_DEPTH;
`else
    localparam int EFF_DEPTH = (NEST_DEPTH < 1) ? NEST_DEPTH : 1;
`endif
    localparam logic [CW-1:0] CHAN_NONE = CW'(chan_none(NUM_INT));

    logic [ADDR_W-1:0]  pc_q, pc_d, pc_inc, nxt;
    logic               flag_q, flag_d, flag_nxt;
    logic [CW-1:0]      cur_q, cur_d;
    logic               ack_q, ack_d, err_q, err_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [NUM_INT-1:0] elig;
    logic               take, push, pop, full, empty;
    logic [EW-1:0]      push_data, pop_data;
    int                 win_i;

    ret_stack #(.W(EW), .DEPTH(EFF_DEPTH)) u_stack (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (push_data),
        .dout  (pop_data),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        pc_inc   = pc_q + ADDR_W'(1);
        nxt      = bus.jmp_en ? bus.target :
                   bus.je_en  ? (flag_q ? bus.target : pc_inc) : pc_inc;
        flag_nxt = bus.je_en ? 1'b0 : bus.flag_w_en ? bus.alu_flag : flag_q;

        // While in an ISR only strictly higher-priority (lower index) channels may pre-empt
        win_i = 0;
        for (int i = 0; i < NUM_INT; i++)
            elig[i] = bus.int_req[i] & bus.int_en[i] & (empty || (CW'(i) < cur_q));
        for (int i = NUM_INT - 1; i >= 0; i--)
            if (elig[i]) win_i = i;
        take      = (|elig) && !full && !bus.ret;
        push_data = {nxt, flag_nxt, cur_q};

        pc_d   = nxt;
        flag_d = flag_nxt;
        cur_d  = cur_q;
        push   = 1'b0;
        pop    = 1'b0;
        ack_d  = 1'b0;
        id_d   = '0;
        err_d  = 1'b0;

        if (bus.ret) begin
            if (!empty) begin
                pop                   = 1'b1;
                {pc_d, flag_d, cur_d} = pop_data;
            end else begin
                pc_d   = pc_inc;
                flag_d = flag_q;
                err_d  = 1'b1;
            end
        end else if (take) begin
            push  = 1'b1;
            pc_d  = bus.int_vec[win_i*ADDR_W +: ADDR_W];
            cur_d = CW'(win_i);
            ack_d = 1'b1;
            id_d  = IDW'(win_i);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q   <= '0;
            flag_q <= 1'b0;
            cur_q  <= CHAN_NONE;
            ack_q  <= 1'b0;
            id_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            flag_q <= flag_d;
            cur_q  <= cur_d;
            ack_q  <= ack_d;
            id_q   <= id_d;
            err_q  <= err_d;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.flag       = flag_q;
    assign bus.in_isr     = !empty;
    assign bus.int_ack    = ack_q;
    assign bus.int_ack_id = id_q;
    assign bus.ret_err    = err_q;
endmodule
